// File: rtl/axil_ram_slave.sv
// AXI-Lite slave backed by a word-addressed on-chip RAM window, with a fixed
// number of wait states before every B and R response.
//
// state     | meaning
// W_IDLE    | no write in progress, AW and W both accepted
// W_COLLECT | one of AW/W captured, waiting for the other
// W_WAIT    | both captured, counting down wait states
// W_RESP    | write committed, bvalid held until bready
// R_IDLE    | arready high, waiting for AR
// R_WAIT    | address latched, counting down wait states
// R_RESP    | rdata/rresp registered, rvalid held until rready
module axil_ram_slave #(
    parameter int              WIDTH     = 32,
    parameter int              DEPTH     = 1024,
    parameter logic [WIDTH-1:0] BASE_ADDR = '0,
    parameter int              LATENCY   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   s_axil_awaddr,
    input  logic [2:0]         s_axil_awprot,
    input  logic               s_axil_awvalid,
    output logic               s_axil_awready,
    input  logic [WIDTH-1:0]   s_axil_wdata,
    input  logic [WIDTH/8-1:0] s_axil_wstrb,
    input  logic               s_axil_wvalid,
    output logic               s_axil_wready,
    output logic [1:0]         s_axil_bresp,
    output logic               s_axil_bvalid,
    input  logic               s_axil_bready,
    input  logic [WIDTH-1:0]   s_axil_araddr,
    input  logic [2:0]         s_axil_arprot,
    input  logic               s_axil_arvalid,
    output logic               s_axil_arready,
    output logic [WIDTH-1:0]   s_axil_rdata,
    output logic [1:0]         s_axil_rresp,
    output logic               s_axil_rvalid,
    input  logic               s_axil_rready
);

    localparam int               BYTES  = WIDTH / 8;
    localparam int               LSB    = $clog2(BYTES);
    localparam int               IDX_W  = $clog2(DEPTH);
    localparam logic [WIDTH-1:0] SPAN   = WIDTH'(DEPTH * BYTES);
    localparam logic [3:0]       LAT    = 4'(LATENCY);
    localparam logic [1:0]       OKAY   = 2'b00;
    localparam logic [1:0]       SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_COLLECT, W_WAIT, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;

    w_state_t           w_state;
    r_state_t           r_state;
    logic [WIDTH-1:0]   mem [DEPTH];

    logic [WIDTH-1:0]   awaddr_q;
    logic [WIDTH-1:0]   wdata_q;
    logic [BYTES-1:0]   wstrb_q;
    logic               aw_done;
    logic               w_done;
    logic [3:0]         w_cnt;
    logic [WIDTH-1:0]   araddr_q;
    logic [3:0]         r_cnt;

    logic               aw_got;
    logic               w_got;
    logic               wr_commit;
    logic [WIDTH-1:0]   aw_off;
    logic [WIDTH-1:0]   ar_off;
    logic               aw_hit;
    logic               ar_hit;
    logic [IDX_W-1:0]   aw_idx;
    logic [IDX_W-1:0]   ar_idx;
    logic               unused_ok;

    // An address below BASE_ADDR wraps to a huge offset, so one compare covers both bounds.
    assign aw_off    = awaddr_q - BASE_ADDR;
    assign ar_off    = araddr_q - BASE_ADDR;
    assign aw_hit    = aw_off < SPAN;
    assign ar_hit    = ar_off < SPAN;
    assign aw_idx    = aw_off[LSB +: IDX_W];
    assign ar_idx    = ar_off[LSB +: IDX_W];
    assign unused_ok = ^{s_axil_awprot, s_axil_arprot, aw_off, ar_off};

    assign aw_got    = aw_done | (s_axil_awvalid & s_axil_awready);
    assign w_got     = w_done  | (s_axil_wvalid  & s_axil_wready);
    assign wr_commit = (w_state == W_WAIT) && (w_cnt == '0) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state        <= W_IDLE;
            aw_done        <= 1'b0;
            w_done         <= 1'b0;
            w_cnt          <= '0;
            s_axil_awready <= 1'b0;
            s_axil_wready  <= 1'b0;
            s_axil_bvalid  <= 1'b0;
            s_axil_bresp   <= OKAY;
        end else begin
            case (w_state)
                W_IDLE, W_COLLECT: begin
                    if (s_axil_awvalid && s_axil_awready) begin
                        awaddr_q <= s_axil_awaddr;
                    end
                    if (s_axil_wvalid && s_axil_wready) begin
                        wdata_q <= s_axil_wdata;
                        wstrb_q <= s_axil_wstrb;
                    end
                    if (aw_got && w_got) begin
                        w_state        <= W_WAIT;
                        w_cnt          <= LAT;
                        aw_done        <= 1'b0;
                        w_done         <= 1'b0;
                        s_axil_awready <= 1'b0;
                        s_axil_wready  <= 1'b0;
                    end else begin
                        w_state        <= (aw_got || w_got) ? W_COLLECT : W_IDLE;
                        aw_done        <= aw_got;
                        w_done         <= w_got;
                        s_axil_awready <= !aw_got;
                        s_axil_wready  <= !w_got;
                    end
                end
                W_WAIT: begin
                    if (w_cnt == '0) begin
                        w_state       <= W_RESP;
                        s_axil_bvalid <= 1'b1;
                        s_axil_bresp  <= aw_hit ? OKAY : SLVERR;
                    end else begin
                        w_cnt <= w_cnt - 4'd1;
                    end
                end
                W_RESP: begin
                    if (s_axil_bready) begin
                        w_state        <= W_IDLE;
                        s_axil_bvalid  <= 1'b0;
                        s_axil_bresp   <= OKAY;
                        s_axil_awready <= 1'b1;
                        s_axil_wready  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_commit && aw_hit) begin
            for (int b = 0; b < BYTES; b++) begin
                if (wstrb_q[b]) begin
                    mem[aw_idx][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

    // The RAM read below sees the pre-commit contents on a same-edge collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= R_IDLE;
            r_cnt          <= '0;
            s_axil_arready <= 1'b0;
            s_axil_rvalid  <= 1'b0;
            s_axil_rresp   <= OKAY;
            s_axil_rdata   <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (s_axil_arvalid && s_axil_arready) begin
                        r_state        <= R_WAIT;
                        araddr_q       <= s_axil_araddr;
                        r_cnt          <= LAT;
                        s_axil_arready <= 1'b0;
                    end else begin
                        s_axil_arready <= 1'b1;
                    end
                end
                R_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state       <= R_RESP;
                        s_axil_rvalid <= 1'b1;
                        s_axil_rresp  <= ar_hit ? OKAY : SLVERR;
                        s_axil_rdata  <= ar_hit ? mem[ar_idx] : '0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                R_RESP: begin
                    if (s_axil_rready) begin
                        r_state        <= R_IDLE;
                        s_axil_rvalid  <= 1'b0;
                        s_axil_rresp   <= OKAY;
                        s_axil_rdata   <= '0;
                        s_axil_arready <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axil_ram_slave.sv
// Bench for axil_ram_slave: directed scenarios plus randomized traffic on a
// small word window checked against an array model with byte-mask merging.
module tb_axil_ram_slave;

    localparam int LAT_EXP = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    int total = 0;
    int bad   = 0;

    logic [31:0] model [16];

    axil_ram_slave dut (
        .clk(clk), .rst(rst),
        .s_axil_awaddr(awaddr), .s_axil_awprot(awprot), .s_axil_awvalid(awvalid),
        .s_axil_awready(awready),
        .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid),
        .s_axil_wready(wready),
        .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
        .s_axil_araddr(araddr), .s_axil_arprot(arprot), .s_axil_arvalid(arvalid),
        .s_axil_arready(arready),
        .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid),
        .s_axil_rready(rready)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One write transaction; lat counts edges from the completing AW/W handshake to bvalid.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int aw_dly, input int w_dly,
                            input int b_hold, output logic [1:0] resp, output int lat,
                            output bit ok);
        bit aw_p, w_p, aw_hs, w_hs, b_hs, done;
        int hs_c, bv_c;
        aw_p = 1; w_p = 1; done = 0; hs_c = -1; bv_c = -1; ok = 1; resp = 2'bxx;
        awaddr = addr; wdata = data; wstrb = strb;
        for (int c = 0; c < 100 && !done; c++) begin
            awvalid = aw_p && (c >= aw_dly);
            wvalid  = w_p && (c >= w_dly);
            if (bv_c >= 0) begin
                if (!bvalid || bresp !== resp) ok = 0;
            end else if (bvalid) begin
                bv_c = c;
                resp = bresp;
            end
            if ((!aw_p && awready) || (!w_p && wready)) ok = 0;
            bready = bvalid && (c - bv_c >= b_hold);
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            b_hs  = bvalid && bready;
            tick();
            if (aw_hs) aw_p = 0;
            if (w_hs) w_p = 0;
            if ((aw_hs || w_hs) && !aw_p && !w_p) hs_c = c + 1;
            if (b_hs) done = 1;
        end
        awvalid = 0; wvalid = 0; bready = 0;
        if (!done) ok = 0;
        lat = (hs_c >= 0 && bv_c >= 0) ? bv_c - hs_c : -1;
    endtask

    task automatic do_read(input logic [31:0] addr, input int ar_dly, input int r_hold,
                           output logic [31:0] data, output logic [1:0] resp,
                           output int lat, output bit ok);
        bit ar_p, ar_hs, r_hs, done;
        int hs_c, rv_c;
        ar_p = 1; done = 0; hs_c = -1; rv_c = -1; ok = 1; data = 'x; resp = 2'bxx;
        araddr = addr;
        for (int c = 0; c < 100 && !done; c++) begin
            arvalid = ar_p && (c >= ar_dly);
            if (rv_c >= 0) begin
                if (!rvalid || rdata !== data || rresp !== resp) ok = 0;
            end else if (rvalid) begin
                rv_c = c;
                data = rdata;
                resp = rresp;
            end
            if (!rvalid && rdata !== 32'h0) ok = 0;
            if (!ar_p && arready) ok = 0;
            rready = rvalid && (c - rv_c >= r_hold);
            ar_hs = arvalid && arready;
            r_hs  = rvalid && rready;
            tick();
            if (ar_hs) begin
                ar_p = 0;
                hs_c = c + 1;
            end
            if (r_hs) done = 1;
        end
        arvalid = 0; rready = 0;
        if (!done) ok = 0;
        lat = (hs_c >= 0 && rv_c >= 0) ? rv_c - hs_c : -1;
    endtask

    initial begin
        logic [1:0]  resp;
        logic [31:0] d, a, mask, rd_col;
        logic [3:0]  s;
        int          lat, w, rv_c, bv_c;
        bit          ok, oor, seen_b;

        rst = 1; awprot = 3'b010; arprot = 3'b001;
        awaddr = 0; wdata = 0; wstrb = 4'hF; araddr = 0;
        awvalid = 1; wvalid = 1; arvalid = 1; bready = 1; rready = 1;

        // Reset held with every valid asserted.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_ready_valid", {27'b0, awready, wready, arready, bvalid, rvalid}, 32'h0);
            check("rst_resp_rdata", rdata | {28'b0, bresp, rresp}, 32'h0);
        end
        rst = 0; awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0;
        tick();
        check("ready_after_rst", {29'b0, awready, wready, arready}, 32'h7);

        // Write then read, AW and W together.
        do_write(32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, resp, lat, ok);
        check("wr1_bresp", {30'b0, resp}, 32'h0);
        check("wr1_lat", lat, LAT_EXP);
        check("wr1_ok", {31'b0, ok}, 32'h1);
        do_read(32'h10, 0, 0, d, resp, lat, ok);
        check("rd1_data", d, 32'hDEADBEEF);
        check("rd1_rresp", {30'b0, resp}, 32'h0);
        check("rd1_lat", lat, LAT_EXP);
        check("rd1_ok", {31'b0, ok}, 32'h1);

        // W four cycles before AW, single byte lane.
        do_write(32'h10, 32'h000000AA, 4'b0001, 4, 0, 0, resp, lat, ok);
        check("wfirst_bresp", {30'b0, resp}, 32'h0);
        check("wfirst_lat", lat, LAT_EXP);
        check("wfirst_ready_ok", {31'b0, ok}, 32'h1);
        do_read(32'h10, 0, 0, d, resp, lat, ok);
        check("wfirst_data", d, 32'hDEADBEAA);

        // Out of range must not alias onto word 0.
        do_write(32'h0, 32'h01234567, 4'hF, 0, 1, 0, resp, lat, ok);
        do_write(32'h1000, 32'hFFFFFFFF, 4'hF, 0, 0, 0, resp, lat, ok);
        check("oor_bresp", {30'b0, resp}, 32'h2);
        check("oor_wr_lat", lat, LAT_EXP);
        do_read(32'h0, 0, 0, d, resp, lat, ok);
        check("oor_ram_unchanged", d, 32'h01234567);
        do_read(32'h1000, 0, 0, d, resp, lat, ok);
        check("oor_rdata", d, 32'h0);
        check("oor_rresp", {30'b0, resp}, 32'h2);

        // Backpressure on B and R.
        do_write(32'h4, 32'hCAFEF00D, 4'hF, 1, 0, 5, resp, lat, ok);
        check("bp_b_stable", {31'b0, ok}, 32'h1);
        check("bp_bresp", {30'b0, resp}, 32'h0);
        do_read(32'h4, 0, 5, d, resp, lat, ok);
        check("bp_r_stable", {31'b0, ok}, 32'h1);
        check("bp_rdata", d, 32'hCAFEF00D);

        // Same-edge read sample and write commit.
        do_write(32'h20, 32'h11111111, 4'hF, 0, 0, 0, resp, lat, ok);
        check("col_ready", {29'b0, awready, wready, arready}, 32'h7);
        awaddr = 32'h20; wdata = 32'h22222222; wstrb = 4'hF; araddr = 32'h20;
        awvalid = 1; wvalid = 1; arvalid = 1; bready = 1; rready = 1;
        tick();
        awvalid = 0; wvalid = 0; arvalid = 0;
        rv_c = -1; bv_c = -1; rd_col = 'x;
        for (int c = 0; c < 20 && (rv_c < 0 || bv_c < 0); c++) begin
            if (rvalid && rv_c < 0) begin
                rv_c = c;
                rd_col = rdata;
            end
            if (bvalid && bv_c < 0) bv_c = c;
            tick();
        end
        bready = 0; rready = 0;
        check("col_same_edge", rv_c, bv_c);
        check("col_old_data", rd_col, 32'h11111111);
        do_read(32'h20, 0, 0, d, resp, lat, ok);
        check("col_new_data", d, 32'h22222222);

        // Reset pulse while the write is waiting.
        awaddr = 32'h20; wdata = 32'h33333333; awvalid = 1; wvalid = 1;
        tick();
        awvalid = 0; wvalid = 0; rst = 1;
        tick();
        rst = 0; bready = 1; seen_b = 0;
        for (int c = 0; c < 10; c++) begin
            if (bvalid) seen_b = 1;
            tick();
        end
        bready = 0;
        check("midrst_no_bvalid", {31'b0, seen_b}, 32'h0);
        check("midrst_ready", {29'b0, awready, wready, arready}, 32'h7);
        do_read(32'h20, 0, 0, d, resp, lat, ok);
        check("midrst_data", d, 32'h22222222);

        // Randomized traffic on words 0x100..0x13C.
        for (int i = 0; i < 16; i++) begin
            d = $urandom;
            model[i] = d;
            do_write(32'h100 + 32'(i * 4), d, 4'hF, 0, 0, 0, resp, lat, ok);
            check("pre_bresp", {30'b0, resp}, 32'h0);
        end
        for (int i = 0; i < 60; i++) begin
            w   = int'($urandom_range(0, 15));
            oor = ($urandom_range(0, 5) == 0);
            a   = oor ? 32'h1000 + 32'($urandom_range(0, 32'h0FFF_0000))
                      : 32'h100 + 32'(w * 4) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                s = 4'($urandom_range(0, 15));
                do_write(a, d, s, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                         int'($urandom_range(0, 2)), resp, lat, ok);
                if (!oor) begin
                    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
                    model[w] = (model[w] & ~mask) | (d & mask);
                end
                check("rnd_bresp", {30'b0, resp}, oor ? 32'h2 : 32'h0);
                check("rnd_wr_lat", lat, LAT_EXP);
                check("rnd_wr_ok", {31'b0, ok}, 32'h1);
            end else begin
                do_read(a, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                        d, resp, lat, ok);
                check("rnd_rdata", d, oor ? 32'h0 : model[w]);
                check("rnd_rresp", {30'b0, resp}, oor ? 32'h2 : 32'h0);
                check("rnd_rd_lat", lat, LAT_EXP);
                check("rnd_rd_ok", {31'b0, ok}, 32'h1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
